// File: rtl/vx_tcu_tfr_align_if.sv
// Beat-level bus between the TCU product stage, the alignment stage and the adder tree.
// Per-lane exception fields are 3 bits: {is_nan, is_inf, sign}.
interface vx_tcu_tfr_align_if #(
  parameter int TCK   = 4,
  parameter int W     = 25,
  parameter int WA    = 28,
  parameter int EXP_W = 10,
  parameter int TAG_W = 32
);
  logic                   valid_in;
  logic                   ready_in;
  logic [TAG_W-1:0]       req_id_in;
  logic [TCK*W-1:0]       sig_in;
  logic [TCK*EXP_W-1:0]   exp_in;
  logic [TCK*3-1:0]       excep_in;
  logic                   valid_out;
  logic                   ready_out;
  logic [TAG_W-1:0]       req_id_out;
  logic [TCK*WA-1:0]      aligned_sig;
  logic [EXP_W-1:0]       max_exp;
  logic [2:0]             excep_out;

  modport slave (
    input  valid_in, req_id_in, sig_in, exp_in, excep_in, ready_out,
    output ready_in, valid_out, req_id_out, aligned_sig, max_exp, excep_out
  );

  modport master (
    output valid_in, req_id_in, sig_in, exp_in, excep_in, ready_out,
    input  ready_in, valid_out, req_id_out, aligned_sig, max_exp, excep_out
  );
endinterface

// File: rtl/vx_tcu_tfr_align.sv
// Two-stage elastic alignment of TCU lane products: stage 1 finds the common
// exponent, stage 2 shifts each lane to it with sticky and emits two's complement.
module vx_tcu_tfr_align #(
  parameter int N     = 2,
  parameter int TCK   = 2*N,
  parameter int W     = 25,
  parameter int WA    = 28,
  parameter int EXP_W = 10,
  parameter int TAG_W = 32
) (
  input logic              clk,
  input logic              reset,
  vx_tcu_tfr_align_if.slave bus
);
  localparam int XW = 3;
  localparam int P  = 1 << $clog2(TCK);
  localparam logic [EXP_W-1:0] WA_LIM = EXP_W'(WA);

  // Pairwise comparator tree, padded with zero leaves up to a power of two.
  function automatic logic [EXP_W-1:0] max_tree(input logic [TCK*EXP_W-1:0] e);
    logic [EXP_W-1:0] v [P];
    for (int i = 0; i < P; i++) begin
      v[i] = (i < TCK) ? e[i*EXP_W +: EXP_W] : '0;
    end
    for (int span = P / 2; span >= 1; span = span / 2) begin
      for (int i = 0; i < span; i++) begin
        v[i] = (v[2*i] > v[2*i+1]) ? v[2*i] : v[2*i+1];
      end
    end
    return v[0];
  endfunction

  function automatic logic [WA-1:0] align_lane(
    input logic [W-1:0]     s,
    input logic [EXP_W-1:0] e,
    input logic [EXP_W-1:0] mx
  );
    logic [EXP_W-1:0] d;
    logic [WA-1:0]    ext;
    logic [WA-1:0]    sh;
    logic             st;
    logic [WA-1:0]    m;
    d   = mx - e;
    ext = {1'b0, s[W-2:0], {(WA-W){1'b0}}};
    if (d < WA_LIM) begin
      sh = ext >> d;
      st = |(ext & ~({WA{1'b1}} << d));
    end else begin
      sh = '0;
      st = |s[W-2:0];
    end
    m = sh | {{(WA-1){1'b0}}, st};
    return s[W-1] ? -m : m;
  endfunction

  logic                 s1_valid_reg;
  logic [TAG_W-1:0]     s1_tag_reg;
  logic [TCK*W-1:0]     s1_sig_reg;
  logic [TCK*EXP_W-1:0] s1_exp_reg;
  logic [TCK*XW-1:0]    s1_excep_reg;
  logic [EXP_W-1:0]     s1_max_reg;

  logic                 valid_out_reg;
  logic [TAG_W-1:0]     tag_out_reg;
  logic [TCK*WA-1:0]    aligned_reg;
  logic [EXP_W-1:0]     max_out_reg;
  logic [XW-1:0]        excep_out_reg;

  logic                 s1_load;
  logic                 s2_load;
  logic                 accept;
  logic [EXP_W-1:0]     max_next;
  logic [TCK*WA-1:0]    aligned_next;
  logic [XW-1:0]        excep_next;
  logic [TCK-1:0]       lane_nan;
  logic [TCK-1:0]       lane_pos_inf;
  logic [TCK-1:0]       lane_neg_inf;

  assign s2_load  = !valid_out_reg || bus.ready_out;
  assign s1_load  = !s1_valid_reg || s2_load;
  assign accept   = bus.valid_in && s1_load;
  assign max_next = max_tree(bus.exp_in);

  for (genvar gi = 0; gi < TCK; gi++) begin : g_lane
    assign aligned_next[gi*WA +: WA] = align_lane(s1_sig_reg[gi*W +: W],
                                                  s1_exp_reg[gi*EXP_W +: EXP_W],
                                                  s1_max_reg);
    assign lane_nan[gi]     = s1_excep_reg[gi*XW+2];
    assign lane_pos_inf[gi] = s1_excep_reg[gi*XW+1] && !s1_excep_reg[gi*XW];
    assign lane_neg_inf[gi] = s1_excep_reg[gi*XW+1] &&  s1_excep_reg[gi*XW];
  end

  // Opposite-signed infinities collapse to NaN; NaN never carries a sign.
  always_comb begin
    excep_next = '0;
    if ((|lane_nan) || ((|lane_pos_inf) && (|lane_neg_inf))) begin
      excep_next = 3'b100;
    end else if ((|lane_pos_inf) || (|lane_neg_inf)) begin
      excep_next = {1'b0, 1'b1, |lane_neg_inf};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg  <= 1'b0;
      s1_tag_reg    <= '0;
      s1_sig_reg    <= '0;
      s1_exp_reg    <= '0;
      s1_excep_reg  <= '0;
      s1_max_reg    <= '0;
      valid_out_reg <= 1'b0;
      tag_out_reg   <= '0;
      aligned_reg   <= '0;
      max_out_reg   <= '0;
      excep_out_reg <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= bus.valid_in;
      end
      if (accept) begin
        s1_tag_reg   <= bus.req_id_in;
        s1_sig_reg   <= bus.sig_in;
        s1_exp_reg   <= bus.exp_in;
        s1_excep_reg <= bus.excep_in;
        s1_max_reg   <= max_next;
      end
      if (s2_load) begin
        valid_out_reg <= s1_valid_reg;
      end
      // Output data only changes when a new beat moves in, so a stall holds it.
      if (s2_load && s1_valid_reg) begin
        tag_out_reg   <= s1_tag_reg;
        aligned_reg   <= aligned_next;
        max_out_reg   <= s1_max_reg;
        excep_out_reg <= excep_next;
      end
    end
  end

  assign bus.ready_in    = s1_load;
  assign bus.valid_out   = valid_out_reg;
  assign bus.req_id_out  = tag_out_reg;
  assign bus.aligned_sig = aligned_reg;
  assign bus.max_exp     = max_out_reg;
  assign bus.excep_out   = excep_out_reg;
endmodule
